// File: rtl/fpu_result_scoreboard.sv
// fpu_result_scoreboard
// Sits on the FPnew result handshake and checks every result against an
// in-order queue of expected values supplied by the stimulus side.
// It can throttle the FPU output with periodic backpressure, and it reports
// mismatches, orphan results and saturating pass/error counters.
// Optional feature: define FPU_SB_NAN_TOLERANT_EN to accept any pair of
// single-precision NaNs as a match. This only applies when WIDTH == 32.
module fpu_result_scoreboard #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int STALL_PERIOD = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       exp_valid_i,
  output logic                       exp_ready_o,
  input  logic [WIDTH-1:0]           exp_result_i,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [WIDTH-1:0]           res_result_i,
  output logic                       mismatch_o,
  output logic [WIDTH-1:0]           mismatch_exp_o,
  output logic [WIDTH-1:0]           mismatch_act_o,
  output logic [31:0]                pass_cnt_o,
  output logic [31:0]                err_cnt_o,
  output logic                       orphan_o,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic                       idle_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SCW-1:0] STALL_LAST = SCW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SCW-1:0]   stall_q, stall_d;
  logic [31:0]      pass_cnt_q, pass_cnt_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic             orphan_q, orphan_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] mm_exp_q, mm_exp_d;
  logic [WIDTH-1:0] mm_act_q, mm_act_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             pop_hit;
  logic             orphan_hit;
  logic [WIDTH-1:0] head;
  logic             nan_both;
  logic             is_match;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign exp_ready_o = !full;
  assign res_ready_o = !((STALL_PERIOD != 0) && (stall_q == STALL_LAST));
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = res_valid_i && res_ready_o;
  assign pop_hit     = pop && !empty;
  assign orphan_hit  = pop && empty;
  assign head        = mem_q[rd_ptr_q];

`ifdef FPU_SB_NAN_TOLERANT_EN
  if (WIDTH == 32) begin : g_nan_tolerant
    assign nan_both = (head[30:23] == 8'hFF) && (head[22:0] != 23'd0) &&
                      (res_result_i[30:23] == 8'hFF) && (res_result_i[22:0] != 23'd0);
  end else begin : g_nan_strict
    assign nan_both = 1'b0;
  end
`else
  assign nan_both = 1'b0;
`endif

  assign is_match = nan_both || (head == res_result_i);

  assign mismatch_o     = mismatch_q;
  assign mismatch_exp_o = mm_exp_q;
  assign mismatch_act_o = mm_act_q;
  assign pass_cnt_o     = pass_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign orphan_o       = orphan_q;
  assign pending_o      = count_q;
  assign idle_o         = empty;

  // Next-state logic: FIFO bookkeeping, stall phase, and compare outcome of this cycle's pop
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop_hit);
    stall_d    = stall_q;
    pass_cnt_d = pass_cnt_q;
    err_cnt_d  = err_cnt_q;
    orphan_d   = orphan_q;
    mismatch_d = 1'b0;
    mm_exp_d   = mm_exp_q;
    mm_act_d   = mm_act_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (STALL_PERIOD != 0) begin
      stall_d = (stall_q == STALL_LAST) ? '0 : stall_q + SCW'(1);
    end

    if (pop_hit) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (is_match) begin
        pass_cnt_d = (pass_cnt_q == 32'hFFFF_FFFF) ? pass_cnt_q : pass_cnt_q + 32'd1;
      end else begin
        mismatch_d = 1'b1;
        err_cnt_d  = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
        mm_exp_d   = head;
        mm_act_d   = res_result_i;
      end
    end

    if (orphan_hit) begin
      orphan_d  = 1'b1;
      err_cnt_d = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
    end
  end

  // Control and status registers, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      pass_cnt_q <= '0;
      err_cnt_q  <= '0;
      orphan_q   <= 1'b0;
      mismatch_q <= 1'b0;
      mm_exp_q   <= '0;
      mm_act_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      pass_cnt_q <= pass_cnt_d;
      err_cnt_q  <= err_cnt_d;
      orphan_q   <= orphan_d;
      mismatch_q <= mismatch_d;
      mm_exp_q   <= mm_exp_d;
      mm_act_q   <= mm_act_d;
    end
  end

  // Expected-result storage; emptiness is tracked by count_q, so no reset is needed here
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= exp_result_i;
    end
  end

endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// tb_fpu_result_scoreboard
// Directed and randomized stimulus for fpu_result_scoreboard (DEPTH=8, STALL_PERIOD=4).
// A queue-based reference model produces the expected outcome of each result
// handshake. A separate monitor pops those outcomes and compares them with the DUT.
// Optional feature under test: FPU_SB_NAN_TOLERANT_EN.
module tb_fpu_result_scoreboard;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int P     = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exp_valid_i;
  logic        exp_ready_o;
  logic [31:0] exp_result_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_result_i;
  logic        mismatch_o;
  logic [31:0] mismatch_exp_o;
  logic [31:0] mismatch_act_o;
  logic [31:0] pass_cnt_o;
  logic [31:0] err_cnt_o;
  logic        orphan_o;
  logic [3:0]  pending_o;
  logic        idle_o;

  fpu_result_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_PERIOD(P)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_result_i(exp_result_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_result_i(res_result_i),
    .mismatch_o(mismatch_o), .mismatch_exp_o(mismatch_exp_o), .mismatch_act_o(mismatch_act_o),
    .pass_cnt_o(pass_cnt_o), .err_cnt_o(err_cnt_o), .orphan_o(orphan_o),
    .pending_o(pending_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mm;
    logic        orph;
    logic [31:0] e;
    logic [31:0] a;
  } ev_t;

  // Reference model state
  logic [31:0] mq[$];
  ev_t         evq[$];
  int unsigned m_phase = 0;
  logic [31:0] m_pass = 0, m_err = 0, m_mexp = 0, m_mact = 0;
  logic        m_orphan = 0;
  logic        m_rdy;
  int          m_sz;
  logic [31:0] m_head;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic ref_match(logic [31:0] e, logic [31:0] a);
`ifdef FPU_SB_NAN_TOLERANT_EN
    if (is_nan(e) && is_nan(a)) return 1'b1;
`endif
    return e === a;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Ready is low on the last cycle of every P-cycle window counted from reset
  function automatic logic ready_now();
    if (P == 0) return 1'b1;
    return m_phase != P - 1;
  endfunction

  function automatic logic [31:0] gen_value();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) v = {v[31], 8'hFF, v[22:1], 1'b1};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic applyStimulus(input logic ev, input logic [31:0] e, input logic rv, input logic [31:0] r);
    exp_valid_i  = ev;
    exp_result_i = e;
    res_valid_i  = rv;
    res_result_i = r;
    @(negedge clk_i);
    exp_valid_i = 1'b0;
    res_valid_i = 1'b0;
  endtask

  // Holds a result valid until the scoreboard is ready to take it
  task automatic deliverResult(input logic [31:0] r);
    logic rdy;
    for (int guard = 0; guard < 16; guard++) begin
      rdy = ready_now();
      applyStimulus(1'b0, 32'h0, 1'b1, r);
      if (rdy) return;
    end
    checkOutput("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    exp_valid_i = 1'b0;
    res_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Reference model: decides acceptance and compare outcome of every clock edge
  always @(posedge clk_i) begin
    if (rst_i) begin
      mq.delete();
      evq.delete();
      m_pass = 0; m_err = 0; m_mexp = 0; m_mact = 0; m_orphan = 0;
      m_phase = 0;
    end else begin
      m_rdy = ready_now();
      m_sz  = mq.size();
      if (res_valid_i && m_rdy) begin
        if (m_sz == 0) begin
          evq.push_back('{mm: 1'b0, orph: 1'b1, e: 32'h0, a: res_result_i});
          m_orphan = 1'b1;
          m_err    = sat_inc(m_err);
        end else begin
          m_head = mq.pop_front();
          if (ref_match(m_head, res_result_i)) begin
            m_pass = sat_inc(m_pass);
            evq.push_back('{mm: 1'b0, orph: 1'b0, e: m_head, a: res_result_i});
          end else begin
            m_err  = sat_inc(m_err);
            m_mexp = m_head;
            m_mact = res_result_i;
            evq.push_back('{mm: 1'b1, orph: 1'b0, e: m_head, a: res_result_i});
          end
        end
      end
      if (exp_valid_i && (m_sz < DEPTH)) mq.push_back(exp_result_i);
      m_phase = (m_phase + 1) % P;
    end
  end

  // Monitor: pops one expected outcome per handshake and checks DUT status every cycle
  always @(negedge clk_i) begin : monitor
    ev_t e;
    if (evq.size() > 0) begin
      e = evq.pop_front();
      checkOutput("ev_mismatch_pulse", {31'd0, mismatch_o}, {31'd0, e.mm});
      if (e.mm) begin
        checkOutput("ev_mismatch_exp", mismatch_exp_o, e.e);
        checkOutput("ev_mismatch_act", mismatch_act_o, e.a);
      end
      if (e.orph) checkOutput("ev_orphan", {31'd0, orphan_o}, 32'd1);
    end else begin
      checkOutput("quiet_mismatch_low", {31'd0, mismatch_o}, 32'd0);
    end
    checkOutput("mon_pass_cnt", pass_cnt_o, m_pass);
    checkOutput("mon_err_cnt", err_cnt_o, m_err);
    checkOutput("mon_orphan", {31'd0, orphan_o}, {31'd0, m_orphan});
    checkOutput("mon_pending", {28'd0, pending_o}, mq.size());
    checkOutput("mon_exp_ready", {31'd0, exp_ready_o}, {31'd0, mq.size() < DEPTH});
    checkOutput("mon_idle", {31'd0, idle_o}, {31'd0, mq.size() == 0});
    checkOutput("mon_res_ready", {31'd0, res_ready_o}, {31'd0, ready_now()});
    checkOutput("mon_held_exp", mismatch_exp_o, m_mexp);
    checkOutput("mon_held_act", mismatch_act_o, m_mact);
  end

  logic [31:0] fpu_q[$];
  logic [31:0] sent[$];
  logic        hold;
  logic [31:0] hold_val;
  logic        rdy, ev, pv;
  logic [31:0] e_val;
  int          lows;

  initial begin
    rst_i = 1'b1; exp_valid_i = 1'b0; exp_result_i = '0; res_valid_i = 1'b0; res_result_i = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_pass", pass_cnt_o, 32'd0);
    checkOutput("rst_err", err_cnt_o, 32'd0);
    checkOutput("rst_orphan", {31'd0, orphan_o}, 32'd0);
    checkOutput("rst_pending", {28'd0, pending_o}, 32'd0);
    checkOutput("rst_exp_ready", {31'd0, exp_ready_o}, 32'd1);
    checkOutput("rst_idle", {31'd0, idle_o}, 32'd1);
    checkOutput("rst_mismatch", {31'd0, mismatch_o}, 32'd0);
    rst_i = 1'b0;

    // Two matching results in order
    applyStimulus(1'b1, 32'h3F80_0000, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 32'h0);
    deliverResult(32'h3F80_0000);
    deliverResult(32'h4000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t1_pass", pass_cnt_o, 32'd2);
    checkOutput("t1_err", err_cnt_o, 32'd0);
    checkOutput("t1_idle", {31'd0, idle_o}, 32'd1);
    doReset();

    // Single mismatch, pulse visible one cycle after the pop
    applyStimulus(1'b1, 32'h3F80_0000, 1'b0, 32'h0);
    deliverResult(32'h3F80_0001);
    checkOutput("t2_pulse_high", {31'd0, mismatch_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t2_pulse_low", {31'd0, mismatch_o}, 32'd0);
    checkOutput("t2_exp", mismatch_exp_o, 32'h3F80_0000);
    checkOutput("t2_act", mismatch_act_o, 32'h3F80_0001);
    checkOutput("t2_err", err_cnt_o, 32'd1);
    doReset();

    // NaN with a different payload
    applyStimulus(1'b1, 32'h7FC0_0000, 1'b0, 32'h0);
    deliverResult(32'h7FC0_0001);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FPU_SB_NAN_TOLERANT_EN
    checkOutput("t3_pass", pass_cnt_o, 32'd1);
    checkOutput("t3_err", err_cnt_o, 32'd0);
`else
    checkOutput("t3_pass", pass_cnt_o, 32'd0);
    checkOutput("t3_err", err_cnt_o, 32'd1);
`endif
    doReset();

    // Fill the FIFO, try one extra push, then free one slot
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h1000 + i, 1'b0, 32'h0);
    checkOutput("t4_full_ready", {31'd0, exp_ready_o}, 32'd0);
    checkOutput("t4_full_pending", {28'd0, pending_o}, DEPTH);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    checkOutput("t4_reject_pending", {28'd0, pending_o}, DEPTH);
    deliverResult(32'h1000);
    checkOutput("t4_ready_again", {31'd0, exp_ready_o}, 32'd1);
    checkOutput("t4_pending_after", {28'd0, pending_o}, DEPTH - 1);
    doReset();

    // Orphan result into an empty FIFO
    deliverResult(32'h1234_5678);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_orphan", {31'd0, orphan_o}, 32'd1);
    checkOutput("t5_err", err_cnt_o, 32'd1);
    doReset();
    checkOutput("t5_rst_orphan", {31'd0, orphan_o}, 32'd0);
    checkOutput("t5_rst_err", err_cnt_o, 32'd0);

    // Result valid held high across stalls while the FIFO is kept nearly full
    sent.delete();
    for (int i = 0; i < DEPTH; i++) begin
      sent.push_back(32'h5000 + i);
      applyStimulus(1'b1, 32'h5000 + i, 1'b0, 32'h0);
    end
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (res_ready_o == 1'b0) lows++;
      rdy   = ready_now();
      pv    = (mq.size() < DEPTH);
      e_val = 32'h6000 + i;
      if (pv) sent.push_back(e_val);
      applyStimulus(pv, e_val, 1'b1, sent[0]);
      if (rdy) void'(sent.pop_front());
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t6_stall_lows", lows, 32'd4);
    checkOutput("t6_pass", pass_cnt_o, 32'd12);
    checkOutput("t6_err", err_cnt_o, 32'd0);
    doReset();

    // Randomized traffic with occasional corruption, NaNs and orphans
    fpu_q.delete();
    hold = 1'b0;
    hold_val = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        if (fpu_q.size() > 0 && $urandom_range(0, 9) < 6) begin
          hold_val = fpu_q.pop_front();
          if ($urandom_range(0, 7) == 0) hold_val = hold_val ^ (32'h1 << $urandom_range(0, 31));
          hold = 1'b1;
        end else if (fpu_q.size() == 0 && mq.size() == 0 && $urandom_range(0, 49) == 0) begin
          hold_val = $urandom;
          hold = 1'b1;
        end
      end
      ev    = ($urandom_range(0, 1) == 1);
      e_val = gen_value();
      if (ev && mq.size() < DEPTH) fpu_q.push_back(e_val);
      rdy = ready_now();
      applyStimulus(ev, e_val, hold, hold_val);
      if (hold && rdy) hold = 1'b0;
    end
    for (int i = 0; i < 200 && (hold || fpu_q.size() > 0); i++) begin
      if (!hold) begin
        hold_val = fpu_q.pop_front();
        hold = 1'b1;
      end
      rdy = ready_now();
      applyStimulus(1'b0, 32'h0, 1'b1, hold_val);
      if (rdy) hold = 1'b0;
    end
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rand_drained", {28'd0, pending_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
